// File: rtl/seg2421_pkg.sv
// Shared constants for the 2421-code display path: segment patterns, code points and a
// validity check for incoming 2421 digits.
package seg2421_pkg;

   // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [3:0] C2421_0 = 4'b0000;
   localparam logic [3:0] C2421_1 = 4'b0001;
   localparam logic [3:0] C2421_2 = 4'b0010;
   localparam logic [3:0] C2421_3 = 4'b0011;
   localparam logic [3:0] C2421_4 = 4'b0100;
   localparam logic [3:0] C2421_5 = 4'b1011;
   localparam logic [3:0] C2421_6 = 4'b1100;
   localparam logic [3:0] C2421_7 = 4'b1101;
   localparam logic [3:0] C2421_8 = 4'b1110;
   localparam logic [3:0] C2421_9 = 4'b1111;

   function automatic logic valid_2421(input logic [3:0] code);
      logic ok;
      case (code)
         C2421_0, C2421_1, C2421_2, C2421_3, C2421_4,
         C2421_5, C2421_6, C2421_7, C2421_8, C2421_9: ok = 1'b1;
         default:                                     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/seg7_dec_2421.sv
// Combinational 2421-digit to 7-segment decoder; unloaded positions are blanked and
// invalid codes show 'E'.
module seg7_dec_2421
   import seg2421_pkg::*;
(
   input  logic [3:0] code,
   input  logic       loaded,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (loaded) begin
         case (code)
            C2421_0: seg = SEG_0;
            C2421_1: seg = SEG_1;
            C2421_2: seg = SEG_2;
            C2421_3: seg = SEG_3;
            C2421_4: seg = SEG_4;
            C2421_5: seg = SEG_5;
            C2421_6: seg = SEG_6;
            C2421_7: seg = SEG_7;
            C2421_8: seg = SEG_8;
            C2421_9: seg = SEG_9;
            default: seg = SEG_E;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan_2421.sv
// Captures a stream of 2421 digits into a shift register and time-multiplexes them onto a
// common-anode 7-segment display with registered segment and anode outputs.
module seg_scan_2421
   import seg2421_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [3:0]        in_code,
   input  logic              clear,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an,
   output logic              err
);

   localparam int unsigned IW = $clog2(DIGITS);
   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam logic [DIGITS-1:0] AN_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

   logic [DIGITS-1:0][3:0] digit_q;
   logic [DIGITS-1:0]      loaded_q;
   logic                   err_q;
   logic [DW-1:0]          div_q, div_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [6:0]             seg_q, seg_d;
   logic [DIGITS-1:0]      an_q, an_d;

   // Capture path; clear wins over a same-cycle sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_q  <= '0;
         loaded_q <= '0;
         err_q    <= 1'b0;
      end else if (clear) begin
         digit_q  <= '0;
         loaded_q <= '0;
         err_q    <= 1'b0;
      end else if (in_valid) begin
         digit_q  <= {digit_q[DIGITS-2:0], in_code};
         loaded_q <= {loaded_q[DIGITS-2:0], 1'b1};
         if (!valid_2421(in_code)) begin
            err_q <= 1'b1;
         end
      end
   end

   seg7_dec_2421 u_dec (
      .code   (digit_q[idx_q]),
      .loaded (loaded_q[idx_q]),
      .seg    (seg_d)
   );

   always_comb begin
      div_d = div_q + DW'(1);
      idx_d = idx_q;
      an_d  = ~(AN_ONE << idx_q);
      if (div_q == DW'(SCAN_DIV - 1)) begin
         div_d = '0;
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         idx_q <= '0;
         seg_q <= SEG_BLANK;
         an_q  <= '1;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign err = err_q;

endmodule

// File: tb/tb_seg_scan_2421.sv
// Self-checking bench for seg_scan_2421 (DIGITS=4, SCAN_DIV=4) using an expectation queue.
module tb_seg_scan_2421;

   localparam int D  = 4;
   localparam int SD = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [3:0]   in_code = 4'b0000;
   logic         clear = 1'b0;
   logic [6:0]   seg;
   logic [D-1:0] an;
   logic         err;

   typedef struct {
      logic [6:0]   seg;
      logic [D-1:0] an;
      logic         err;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   // Reference state: edges since reset release and the expected digit store
   int         cyc;
   logic [3:0] m_dig[D];
   logic       m_ld[D];
   logic       m_err;

   seg_scan_2421 #(.DIGITS(D), .SCAN_DIV(SD)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_code  (in_code),
      .clear    (clear),
      .seg      (seg),
      .an       (an),
      .err      (err)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_seg(input logic [3:0] c, input logic ld);
      if (!ld) return 7'h00;
      case (c)
         4'b0000: return 7'h3F;
         4'b0001: return 7'h06;
         4'b0010: return 7'h5B;
         4'b0011: return 7'h4F;
         4'b0100: return 7'h66;
         4'b1011: return 7'h6D;
         4'b1100: return 7'h7D;
         4'b1101: return 7'h07;
         4'b1110: return 7'h7F;
         4'b1111: return 7'h6F;
         default: return 7'h79;
      endcase
   endfunction

   function automatic logic ref_bad(input logic [3:0] c);
      return (c >= 4'b0101) && (c <= 4'b1010);
   endfunction

   task automatic model_reset();
      cyc   = 0;
      m_err = 1'b0;
      for (int i = 0; i < D; i++) begin
         m_dig[i] = 4'b0000;
         m_ld[i]  = 1'b0;
      end
   endtask

   // Drive one cycle of stimulus, queue the outputs expected after the edge, advance the clock
   task automatic step(input logic v, input logic [3:0] c, input logic clr);
      exp_t x;
      int   idx;
      idx      = (cyc / SD) % D;
      x.an     = ~(D'(1) << idx);
      x.seg    = ref_seg(m_dig[idx], m_ld[idx]);
      in_valid = v;
      in_code  = c;
      clear    = clr;
      if (clr) begin
         for (int i = 0; i < D; i++) begin
            m_dig[i] = 4'b0000;
            m_ld[i]  = 1'b0;
         end
         m_err = 1'b0;
      end else if (v) begin
         for (int i = D - 1; i > 0; i--) begin
            m_dig[i] = m_dig[i-1];
            m_ld[i]  = m_ld[i-1];
         end
         m_dig[0] = c;
         m_ld[0]  = 1'b1;
         if (ref_bad(c)) m_err = 1'b1;
      end
      x.err = m_err;
      q.push_back(x);
      cyc++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (seg !== 7'h00 || an !== 4'b1111 || err !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: seg=%h an=%b err=%b want seg=00 an=1111 err=0", seg, an, err);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      total++;
      if (seg !== 7'h00 || an !== 4'b1111 || err !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: seg=%h an=%b err=%b want seg=00 an=1111", seg, an, err);
      end
      step(1'b0, 4'b0000, 1'b0);
      e = q.pop_front();
      total++;
      if (an !== 4'b1110 || seg !== 7'h00 || an !== e.an) begin
         bad++;
         $display("FAIL first_edge: an=%b seg=%h want an=1110 seg=00", an, seg);
      end
   endtask

   task automatic test_scan_idle();
      for (int k = 0; k < 2 * D * SD; k++) begin
         step(1'b0, 4'b0000, 1'b0);
         e = q.pop_front();
         total++;
         if (an !== e.an || seg !== e.seg || err !== e.err) begin
            bad++;
            $display("FAIL scan_idle[%0d]: an=%b seg=%h err=%b want an=%b seg=%h err=%b",
                     k, an, seg, err, e.an, e.seg, e.err);
         end
         total++;
         if (an == '1 || !$onehot(~an)) begin
            bad++;
            $display("FAIL an_onehot[%0d]: an=%b want exactly one low bit", k, an);
         end
      end
   endtask

   task automatic test_capture(input logic [3:0] c0, input logic [3:0] c1,
                               input logic [3:0] c2, input logic [3:0] c3,
                               input logic [3:0] c4, input int n, input string name);
      logic [3:0] codes[5];
      codes = '{c0, c1, c2, c3, c4};
      for (int k = 0; k < n + D * SD; k++) begin
         if (k < n) step(1'b1, codes[k], 1'b0);
         else       step(1'b0, 4'b0000, 1'b0);
         e = q.pop_front();
         total++;
         if (an !== e.an || seg !== e.seg || err !== e.err) begin
            bad++;
            $display("FAIL %s[%0d]: an=%b seg=%h err=%b want an=%b seg=%h err=%b",
                     name, k, an, seg, err, e.an, e.seg, e.err);
         end
      end
   endtask

   task automatic test_clear();
      step(1'b1, 4'b0011, 1'b1);
      e = q.pop_front();
      total++;
      if (err !== 1'b0 || err !== e.err) begin
         bad++;
         $display("FAIL clear_err: err=%b want 0", err);
      end
      for (int k = 0; k < D * SD + 1; k++) begin
         step(1'b0, 4'b0000, 1'b0);
         e = q.pop_front();
         total++;
         if (seg !== 7'h00 || an !== e.an || err !== 1'b0) begin
            bad++;
            $display("FAIL clear_blank[%0d]: an=%b seg=%h err=%b want an=%b seg=00 err=0",
                     k, an, seg, err, e.an);
         end
      end
   endtask

   task automatic test_async_reset();
      repeat (3) begin
         step(1'b0, 4'b0000, 1'b0);
         e = q.pop_front();
      end
      total++;
      if (seg === 7'h00 || an !== e.an) begin
         bad++;
         $display("FAIL pre_reset_frame: an=%b seg=%h want an=%b seg=%h", an, seg, e.an, e.seg);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (an !== 4'b1111 || seg !== 7'h00 || err !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: an=%b seg=%h err=%b want an=1111 seg=00 err=0",
                  an, seg, err);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_scan_idle();
      test_capture(4'b0001, 4'b1011, 4'b1111, 4'b0100, 4'b0000, 4, "capture_1594");
      test_capture(4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, "invalid_code");
      test_capture(4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, "err_sticky");
      test_clear();
      test_capture(4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 5, "shift_out");
      test_async_reset();
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain: left=%0d want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded bound");
      $fatal(1, "timeout");
   end

endmodule
